ifu_fetch: RTL
==============

# ifu_fetch

Instruction fetch unit for the femtoRV32 core; sits directly upstream of decode and the main control decoder. It owns the PC, issues in-order requests to instruction memory over a valid/ready handshake, and buffers returned words in a 2-entry queue. It presents `{inst, inst_pc, opcode}` to decode with a valid/ready handshake, and flushes on branch/jump redirects, discarding stale in-flight responses.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; must be word-aligned.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- One clock; reset is asynchronous and active-low.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_req_addr`  out  32  word-aligned fetch address; equals `fetch_pc`.
- `imem_rsp_valid`  in  1  response data valid. Responses are in order, arrive at least 1 cycle after acceptance, and cannot be back-pressured.
- `imem_rsp_data`  in  32  instruction word.
- `redirect_valid`  in  1  branch/JAL/JALR taken; flush and refetch.
- `redirect_pc`  in  32  new fetch address.
- `inst_valid`  out  1  head entry filled and not being flushed.
- `inst_ready`  in  1  decode consumes the head this cycle.
- `inst`  out  32  head instruction word.
- `inst_pc`  out  32  head instruction address.
- `opcode`  out  5  `inst[6:2]`; drives the main control decoder.

## Operation
- **State:**
  - `fetch_pc` (32).
  - 2-entry circular queue; each entry is `{alloc, filled, pc, data}`.
  - Head and tail pointers, 1 bit each.
  - `drop_cnt` (0..2).
- **Slot rule:** `free = 2 - allocated - drop_cnt`, plus 1 if a pop occurs this cycle.
  - `imem_req_valid = (free > 0) && !redirect_valid`.
- **Request accepted** (`imem_req_valid && imem_req_ready`):
  - Allocate the tail entry with `pc = fetch_pc`, `filled = 0`.
  - Advance the tail; `fetch_pc += 4`, wrapping modulo 2^32.
- **Response:**
  - If `drop_cnt > 0`: decrement `drop_cnt` and discard the data.
  - Otherwise: write the data into the oldest allocated, unfilled entry and set `filled`.
- **Pop** (`inst_valid && inst_ready`): clear the head entry and advance the head.
- **Redirect:**
  - Clear all entries and reset both pointers to 0.
  - `drop_cnt <= drop_cnt + (number of allocated unfilled entries)`, minus 1 if a response arrives this same cycle.
  - `fetch_pc <= redirect_pc`.
- **Simultaneous events:**
  - Redirect beats pop: `inst_valid` is forced low, so no pop occurs.
  - A response in the redirect cycle is always stale and is discarded.
  - Pop and response in the same cycle to different entries are both performed.
  - A response arriving with no allocated unfilled entry and `drop_cnt == 0` is a protocol error and is ignored.

## Timing
- **Reset values:**
  - `imem_req_valid = 0` while `rst_n` is low.
  - `fetch_pc = RESET_PC`; queue empty; `drop_cnt = 0`.
  - `inst_valid = 0`; `inst`, `inst_pc`, `opcode` = 0.
- **After reset release:** first request is asserted in the first cycle after `rst_n` deasserts.
- **Reset mid-operation:** asynchronously clears everything. Responses to pre-reset requests are the memory's responsibility.
- **Latency:** response cycle t gives `inst_valid` at t+1, because queue data is registered.
- **Throughput:** with 1-cycle memory and `inst_ready` held high, sustained 1 instruction/cycle.
- **Redirect at cycle t:**
  - Target request is issued at t+1 if `free > 0`.
  - If `drop_cnt == 2`, the request stalls until one stale response drains.
- **Combinational paths:**
  - `imem_req_valid` depends on `inst_ready` and `redirect_valid`.
  - Outputs `inst`/`inst_pc`/`opcode` are driven from registers only.

## Configuration
- **`IFU_MISALIGN_CHECK_EN` defined:**
  - Adds output port `fetch_misaligned` (1 bit, reset 0).
  - A redirect with `redirect_pc[1:0] != 0` flushes as normal, sets `fetch_misaligned`, and holds `imem_req_valid` low.
  - `fetch_misaligned` stays set until the next aligned redirect or reset.
- **Undefined:**
  - No port.
  - `redirect_pc[1:0]` is forced to 2'b00 when loaded into `fetch_pc`.

## Test plan
- **Reset fetch:** release reset, `RESET_PC = 0`, 1-cycle memory, `inst_ready = 1` -> requests to 0x0, 0x4, 0x8 on consecutive cycles; `inst_pc` 0x0, 0x4, 0x8 in consecutive cycles from cycle 2; `opcode = inst[6:2]`.
- **Backpressure:** `inst_ready = 0` for 5 cycles -> at most 2 requests accepted, then `imem_req_valid = 0`. Release -> in-order delivery with no loss or duplication.
- **Redirect with 2 in flight:**
  - Stimulus: 3-cycle memory latency, redirect to 0x100 while 0x8 and 0xC are outstanding.
  - Required: both responses discarded; 0x100 requested once `drop_cnt < 2`; first `inst_pc = 0x100`.
- **Redirect + pop + response same cycle:** head consumed not counted, incoming word discarded; next delivered `inst_pc = redirect_pc`.
- **Wrap-around:** redirect to 0xFFFF_FFFC -> next request address is 0x0000_0000.
- **Misaligned redirect** (macro on: redirect to 0x102; macro off: redirect to 0x102):
  - Macro on: `fetch_misaligned = 1`, no further requests until redirect to 0x200.
  - Macro off: fetch proceeds from 0x100.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues in-order imem requests and queues returned words for decode.
// Optional IFU_MISALIGN_CHECK_EN adds fetch_misaligned and halts fetch after a misaligned redirect.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [4:0]  opcode
`ifdef IFU_MISALIGN_CHECK_EN
    ,
    output logic        fetch_misaligned
`endif
);

    logic [31:0] fetch_pc, fetch_pc_n;
    logic [1:0]  alloc, alloc_n;
    logic [1:0]  filled, filled_n;
    logic [31:0] ent_pc [2];
    logic [31:0] ent_pc_n [2];
    logic [31:0] ent_data [2];
    logic [31:0] ent_data_n [2];
    logic        head, head_n;
    logic        tail, tail_n;
    logic [1:0]  drop_cnt, drop_n;

    logic [1:0]  unfilled;
    logic [1:0]  alloc_cnt;
    logic [1:0]  unfilled_cnt;
    logic [2:0]  used;
    logic [2:0]  drop_sum;
    logic        pop;
    logic        accept;
    logic        has_slot;
    logic        rsp_idx;
    logic        rsp_hit;
    logic        misaligned;
    logic        misaligned_n;

    assign unfilled     = alloc & ~filled;
    assign alloc_cnt    = {1'b0, alloc[0]} + {1'b0, alloc[1]};
    assign unfilled_cnt = {1'b0, unfilled[0]} + {1'b0, unfilled[1]};
    assign used         = {1'b0, alloc_cnt} + {1'b0, drop_cnt};

    assign inst_valid = alloc[head] & filled[head] & ~redirect_valid;
    assign pop        = inst_valid & inst_ready;

    // A pop this cycle frees a slot that the new request may reuse immediately.
    assign has_slot       = (used < 3'd2) || (pop && (used == 3'd2));
    assign imem_req_valid = rst_n & has_slot & ~redirect_valid & ~misaligned;
    assign imem_req_addr  = fetch_pc;
    assign accept         = imem_req_valid & imem_req_ready;

    // Entries are allocated in order from head, so the oldest unfilled one is head or head+1.
    assign rsp_idx = unfilled[head] ? head : ~head;
    assign rsp_hit = unfilled[rsp_idx];

    assign inst    = ent_data[head];
    assign inst_pc = ent_pc[head];
    assign opcode  = ent_data[head][6:2];

    always_comb begin
        fetch_pc_n   = fetch_pc;
        alloc_n      = alloc;
        filled_n     = filled;
        ent_pc_n     = ent_pc;
        ent_data_n   = ent_data;
        head_n       = head;
        tail_n       = tail;
        drop_n       = drop_cnt;
        misaligned_n = misaligned;
        drop_sum     = {1'b0, drop_cnt} + {1'b0, unfilled_cnt};

        if (redirect_valid) begin
            alloc_n       = '0;
            filled_n      = '0;
            ent_pc_n[0]   = '0;
            ent_pc_n[1]   = '0;
            ent_data_n[0] = '0;
            ent_data_n[1] = '0;
            head_n        = 1'b0;
            tail_n        = 1'b0;
            // A response landing now answers the oldest outstanding request, so it is one fewer to drop.
            if (imem_rsp_valid && (drop_sum != 3'd0)) begin
                drop_sum = drop_sum - 3'd1;
            end
            drop_n       = drop_sum[1:0];
            fetch_pc_n   = redirect_pc & 32'hFFFF_FFFC;
            misaligned_n = |redirect_pc[1:0];
        end else begin
            if (imem_rsp_valid) begin
                if (drop_cnt != 2'd0) begin
                    drop_n = drop_cnt - 2'd1;
                end else if (rsp_hit) begin
                    filled_n[rsp_idx]   = 1'b1;
                    ent_data_n[rsp_idx] = imem_rsp_data;
                end
            end
            if (pop) begin
                alloc_n[head]    = 1'b0;
                filled_n[head]   = 1'b0;
                ent_pc_n[head]   = '0;
                ent_data_n[head] = '0;
                head_n           = ~head;
            end
            if (accept) begin
                alloc_n[tail]    = 1'b1;
                filled_n[tail]   = 1'b0;
                ent_pc_n[tail]   = fetch_pc;
                ent_data_n[tail] = '0;
                tail_n           = ~tail;
                fetch_pc_n       = fetch_pc + 32'd4;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            alloc       <= '0;
            filled      <= '0;
            ent_pc[0]   <= '0;
            ent_pc[1]   <= '0;
            ent_data[0] <= '0;
            ent_data[1] <= '0;
            head        <= 1'b0;
            tail        <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            fetch_pc    <= fetch_pc_n;
            alloc       <= alloc_n;
            filled      <= filled_n;
            ent_pc[0]   <= ent_pc_n[0];
            ent_pc[1]   <= ent_pc_n[1];
            ent_data[0] <= ent_data_n[0];
            ent_data[1] <= ent_data_n[1];
            head        <= head_n;
            tail        <= tail_n;
            drop_cnt    <= drop_n;
        end
    end

`ifdef IFU_MISALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misaligned <= 1'b0;
        end else begin
            misaligned <= misaligned_n;
        end
    end

    assign fetch_misaligned = misaligned;
`else
    assign misaligned = 1'b0;
`endif

endmodule
